// File: rtl/md_seq_ctrl.sv
// md_seq_ctrl
// Sequences one HI/LO multiply/divide op at a time for the EX stage.
// Divides go through the external iterative divider (level start, ready
// return, annul to abort or return it to idle). Multiplies launch the external
// pipelined multiplier and wait a fixed MUL_LAT cycles. The result is held
// while the downstream stage stalls and written to HI/LO in a single-cycle
// pulse. A flush kills the op in flight.
//
// Optional build macro: MD_DIVZERO_FAST_EN
//   When defined, a DIV/DIVU whose divisor is zero bypasses the divider.
//   It completes in the cycle after accept with {a, 32'hFFFF_FFFF}.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     kill the in-flight op; return to IDLE
//   stall_in                  downstream stall; DONE holds the result
//   op_valid, op, a, b        md op from EX (00 MULT 01 MULTU 10 DIV 11 DIVU)
//   div_start/signed/annul    divider control
//   div_a, div_b              latched divide operands
//   div_result, div_ready     {rem, quo} and its valid flag from the divider
//   mul_start, mul_signed     multiplier launch pulse and sign select
//   mul_a, mul_b              latched multiply operands
//   mul_result                {hi, lo} product from the multiplier
//   md_stall                  stall request to the hazard unit
//   hilo_we, hilo_wdata       HI/LO write pulse and data {HI, LO}
//   busy                      sequencer is not idle
//
// state   | meaning
// IDLE    | waiting for an md op from EX
// DIV_RUN | divider running, waiting for div_ready
// MUL_RUN | multiplier pipeline in flight, latency counter running
// DONE    | result held, written when the pipeline is not stalled

module md_seq_ctrl #(
    parameter int MUL_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        stall_in,
    input  logic        op_valid,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        div_start,
    output logic        div_signed,
    output logic        div_annul,
    output logic [31:0] div_a,
    output logic [31:0] div_b,
    input  logic [63:0] div_result,
    input  logic        div_ready,
    output logic        mul_start,
    output logic        mul_signed,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic [63:0] mul_result,
    output logic        md_stall,
    output logic        hilo_we,
    output logic [63:0] hilo_wdata,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, DIV_RUN, MUL_RUN, DONE} state_t;

    state_t             state_q;
    state_t             state_d;
    logic [31:0]        a_q;
    logic [31:0]        b_q;
    logic               signed_q;
    logic               was_div_q;
    logic               mul_first_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [63:0]        result_q;
    logic               accept;
    logic               fast_zero;

    assign accept = (state_q == IDLE) && op_valid && !flush;

`ifdef MD_DIVZERO_FAST_EN
    assign fast_zero = op[1] && (b == 32'd0);
`else
    assign fast_zero = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            signed_q    <= 1'b0;
            was_div_q   <= 1'b0;
            mul_first_q <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q         <= a;
                b_q         <= b;
                signed_q    <= ~op[0];
                was_div_q   <= op[1];
                mul_first_q <= ~op[1];
                // Loaded at accept so the capture lands MUL_LAT cycles later.
                if (!op[1]) begin
                    cnt_q <= CNT_W'(MUL_LAT - 1);
                end
                if (fast_zero) begin
                    result_q <= {a, 32'hFFFF_FFFF};
                end
            end else begin
                mul_first_q <= 1'b0;
                if (state_q == MUL_RUN && cnt_q != '0) begin
                    cnt_q <= cnt_q - CNT_W'(1);
                end
            end
            // A flush discards whatever completes in the same cycle.
            if (!flush) begin
                if (state_q == DIV_RUN && div_ready) begin
                    result_q <= div_result;
                end
                if (state_q == MUL_RUN && cnt_q == '0) begin
                    result_q <= mul_result;
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        md_stall   = 1'b0;
        hilo_we    = 1'b0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_annul  = 1'b0;
        mul_start  = 1'b0;
        mul_signed = 1'b0;
        case (state_q)
            IDLE: begin
                md_stall = op_valid && !flush;
                if (accept) begin
                    if (fast_zero) begin
                        state_d = DONE;
                    end else if (op[1]) begin
                        state_d = DIV_RUN;
                    end else begin
                        state_d = MUL_RUN;
                    end
                end
            end
            DIV_RUN: begin
                div_start  = 1'b1;
                div_signed = signed_q;
                md_stall   = 1'b1;
                if (div_ready) begin
                    state_d = DONE;
                end
            end
            MUL_RUN: begin
                mul_start  = mul_first_q;
                mul_signed = signed_q;
                md_stall   = 1'b1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                hilo_we   = !stall_in;
                div_annul = was_div_q;
                if (!stall_in) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush) begin
            state_d = IDLE;
            hilo_we = 1'b0;
            if (state_q == DIV_RUN) begin
                div_annul = 1'b1;
            end
        end
    end

    assign div_a      = a_q;
    assign div_b      = b_q;
    assign mul_a      = a_q;
    assign mul_b      = b_q;
    assign hilo_wdata = result_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_md_seq_ctrl.sv
`timescale 1ns/1ps
module tb_md_seq_ctrl;
    localparam int MUL_LAT = 2;
    localparam int INF     = 32'h3fff_ffff;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0, stall_in = 1'b0, op_valid = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        div_start, div_signed, div_annul, div_ready;
    logic [31:0] div_a, div_b, mul_a, mul_b;
    logic [63:0] div_result, mul_result, hilo_wdata;
    logic        mul_start, mul_signed, md_stall, hilo_we, busy;

    md_seq_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
        .op_valid(op_valid), .op(op), .a(a), .b(b),
        .div_start(div_start), .div_signed(div_signed), .div_annul(div_annul),
        .div_a(div_a), .div_b(div_b), .div_result(div_result), .div_ready(div_ready),
        .mul_start(mul_start), .mul_signed(mul_signed), .mul_a(mul_a), .mul_b(mul_b),
        .mul_result(mul_result), .md_stall(md_stall), .hilo_we(hilo_we),
        .hilo_wdata(hilo_wdata), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // {HI, LO} for an md op: products are 64-bit, divides give {rem, quo};
    // a zero divisor yields {dividend, all ones}.
    function automatic logic [63:0] md_ref(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] q, r;
        case (o)
            2'b00: return $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
            2'b01: return {32'd0, x} * {32'd0, y};
            default: begin
                if (y == 32'd0) return {x, 32'hFFFF_FFFF};
                if (o == 2'b10) begin
                    q = $signed(x) / $signed(y);
                    r = $signed(x) % $signed(y);
                end else begin
                    q = x / y;
                    r = x % y;
                end
                return {r, q};
            end
        endcase
    endfunction

    // Divider model: ready div_lat cycles after the first div_start cycle.
    int          div_lat = 4;
    logic        dv_busy = 1'b0, dv_started = 1'b0;
    int          dv_cnt = 0;
    logic [63:0] dv_res = '0;
    always @(posedge clk) begin
        if (!div_start || div_annul) begin
            dv_busy    <= 1'b0;
            dv_started <= 1'b0;
        end else if (!dv_started) begin
            dv_started <= 1'b1;
            dv_busy    <= 1'b1;
            dv_cnt     <= div_lat - 1;
            dv_res     <= md_ref({1'b1, ~div_signed}, div_a, div_b);
        end else if (dv_cnt != 0) begin
            dv_cnt <= dv_cnt - 1;
        end
    end
    assign div_ready  = dv_busy && (dv_cnt == 0);
    assign div_result = div_ready ? dv_res : 64'hDEAD_BEEF_DEAD_BEEF;

    // Multiplier model: product valid MUL_LAT-1 cycles after the mul_start cycle.
    int          mp_since = 100;
    logic [63:0] mp_prod = '0;
    always @(posedge clk) begin
        if (mul_start) begin
            mp_since <= 1;
            mp_prod  <= md_ref({1'b0, ~mul_signed}, mul_a, mul_b);
        end else if (mp_since < 100) begin
            mp_since <= mp_since + 1;
        end
    end
    assign mul_result = (mp_since == MUL_LAT - 1) ? mp_prod : 64'hBAD0_BAD0_BAD0_BAD0;

    int n_cmp = 0, n_bad = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Transaction-level reference: one op in flight, its completion cycle and result.
    logic        m_active = 1'b0, m_div = 1'b0, m_fast = 1'b0, m_signed = 1'b0;
    int          m_t0 = 0, m_done_at = 0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [63:0] m_exp = '0;
    int          n_stall = 0, n_we = 0, n_annul = 0, n_ms = 0, n_ds = 0, n_done = 0, we_cyc = 0;
    logic [63:0] we_data = '0;

    task automatic model_check();
        logic in_run;
        if (rst) begin
            m_active = 1'b0;
            return;
        end
        if (md_stall) n_stall++;
        if (hilo_we) begin
            n_we++;
            we_cyc  = cyc;
            we_data = hilo_wdata;
        end
        if (div_annul) n_annul++;
        if (mul_start) n_ms++;
        if (div_start) n_ds++;
        if (busy && !md_stall) n_done++;
        if (!m_active) begin
            chk("idle_busy", busy, 0);
            chk("idle_md_stall", md_stall, op_valid & !flush);
            chk("idle_hilo_we", hilo_we, 0);
            chk("idle_div_start", div_start, 0);
            chk("idle_mul_start", mul_start, 0);
            chk("idle_div_annul", div_annul, 0);
            if (op_valid && !flush) begin
                m_active = 1'b1;
                m_t0     = cyc;
                m_div    = op[1];
                m_fast   = 1'b0;
`ifdef MD_DIVZERO_FAST_EN
                m_fast   = op[1] && (b == 32'd0);
`endif
                m_signed = ~op[0];
                m_a      = a;
                m_b      = b;
                m_exp    = md_ref(op, a, b);
                m_done_at = m_fast ? cyc + 1 : (m_div ? INF : cyc + MUL_LAT + 1);
            end
        end else begin
            in_run = (cyc < m_done_at);
            chk("busy", busy, 1);
            chk("md_stall", md_stall, in_run);
            chk("hilo_we", hilo_we, !in_run && !stall_in && !flush);
            chk("div_start", div_start, m_div && !m_fast && in_run);
            chk("mul_start", mul_start, !m_div && (cyc == m_t0 + 1));
            chk("div_annul", div_annul, m_div && (!in_run || flush));
            if (in_run && m_div && !m_fast) begin
                chk("div_signed", div_signed, m_signed);
                chk("div_a", div_a, m_a);
                chk("div_b", div_b, m_b);
            end
            if (in_run && !m_div) begin
                chk("mul_signed", mul_signed, m_signed);
                chk("mul_a", mul_a, m_a);
                chk("mul_b", mul_b, m_b);
            end
            if (!in_run && !stall_in && !flush) begin
                chk("hilo_wdata", hilo_wdata, m_exp);
                m_active = 1'b0;
            end
            if (in_run && m_div && div_ready && !flush) m_done_at = cyc + 1;
            if (flush) m_active = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_check();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [63:0] res;
        int          wlat;
        int          ds;
        int          annul;
        int          ms;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v, input string tag);
        int acc, w0, s0, a0, m0, d0;
        bit ok;
        div_lat = v.lat;
        w0 = n_we; s0 = n_stall; a0 = n_annul; m0 = n_ms; d0 = n_ds;
        op_valid = 1'b1; op = v.op; a = v.a; b = v.b;
        acc = cyc;
        tick();
        op_valid = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (n_we != w0) begin ok = 1'b1; break; end
            tick();
        end
        chk({tag, "_timeout"}, ok, 1);
        chk({tag, "_wdata"}, we_data, v.res);
        chk({tag, "_we_latency"}, we_cyc - acc, v.wlat);
        chk({tag, "_stall_cycles"}, n_stall - s0, v.wlat);
        chk({tag, "_div_start_cycles"}, n_ds - d0, v.ds);
        chk({tag, "_mul_start_pulses"}, n_ms - m0, v.ms);
        repeat (3) tick();
        chk({tag, "_we_pulses"}, n_we - w0, 1);
        chk({tag, "_annul_cycles"}, n_annul - a0, v.annul);
    endtask

    initial begin
        int acc, w0, a0, d0;
        vecs[0] = '{2'b11, 32'd100, 32'd7, 32, 64'h0000_0002_0000_000E, 34, 33, 1, 0};
        vecs[1] = '{2'b00, 32'hFFFF_FFFE, 32'd3, 1, 64'hFFFF_FFFF_FFFF_FFFA, 3, 0, 0, 1};
        vecs[2] = '{2'b01, 32'd4, 32'd5, 1, 64'd20, 3, 0, 0, 1};
        vecs[3] = '{2'b10, 32'hFFFF_FFF7, 32'd2, 5, {32'hFFFF_FFFF, 32'hFFFF_FFFC}, 7, 6, 1, 0};
        vecs[4] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 64'hFFFF_FFFE_0000_0001, 3, 0, 0, 1};
        vecs[5] = '{2'b10, 32'd7, 32'hFFFF_FFFE, 1, 64'h0000_0001_FFFF_FFFD, 3, 2, 1, 0};
`ifdef MD_DIVZERO_FAST_EN
        vecs[6] = '{2'b10, 32'd5, 32'd0, 3, {32'd5, 32'hFFFF_FFFF}, 1, 0, 1, 0};
`else
        vecs[6] = '{2'b10, 32'd5, 32'd0, 3, {32'd5, 32'hFFFF_FFFF}, 5, 4, 1, 0};
`endif

        @(posedge clk); #1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_hilo_wdata", hilo_wdata, 0);
        chk("reset_div_a", div_a, 0);
        chk("reset_mul_b", mul_b, 0);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Divide completing under a 4-cycle downstream stall.
        w0 = n_we; d0 = n_done; div_lat = 5;
        op_valid = 1'b1; op = 2'b10; a = 32'hFFFF_FFF7; b = 32'd2; acc = cyc;
        tick();
        op_valid = 1'b0; stall_in = 1'b1;
        repeat (10) tick();
        chk("stall_no_write", n_we - w0, 0);
        stall_in = 1'b0;
        repeat (3) tick();
        chk("stall_we_pulses", n_we - w0, 1);
        chk("stall_we_latency", we_cyc - acc, 11);
        chk("stall_wdata", we_data, {32'hFFFF_FFFF, 32'hFFFF_FFFC});
        chk("stall_done_cycles", n_done - d0, 5);

        // Flush five cycles into DIV_RUN, then a MULTU.
        w0 = n_we; a0 = n_annul; div_lat = 32;
        op_valid = 1'b1; op = 2'b11; a = 32'd50; b = 32'd3;
        tick();
        op_valid = 1'b0;
        repeat (4) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_run_idle", busy, 0);
        repeat (3) tick();
        chk("flush_run_annul", n_annul - a0, 1);
        chk("flush_run_no_write", n_we - w0, 0);
        run_vec(vecs[2], "after_flush");

        // Flush in the same cycle as div_ready.
        w0 = n_we; div_lat = 3;
        op_valid = 1'b1; op = 2'b10; a = 32'd20; b = 32'd3;
        tick();
        op_valid = 1'b0;
        repeat (3) tick();
        chk("flush_ready_coincide", div_ready, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_ready_idle", busy, 0);
        repeat (3) tick();
        chk("flush_ready_no_write", n_we - w0, 0);

        // Reset in the middle of MUL_RUN.
        op_valid = 1'b1; op = 2'b00; a = 32'h1234; b = 32'd5;
        tick();
        op_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_md_stall", md_stall, 0);
        chk("rst_mid_mul_start", mul_start, 0);
        chk("rst_mid_mul_signed", mul_signed, 0);
        chk("rst_mid_mul_a", mul_a, 0);
        chk("rst_mid_mul_b", mul_b, 0);
        chk("rst_mid_div_a", div_a, 0);
        chk("rst_mid_hilo_we", hilo_we, 0);
        chk("rst_mid_hilo_wdata", hilo_wdata, 0);
        chk("rst_mid_div_ctrl", {div_start, div_signed, div_annul}, 0);
        tick();

        // Random traffic against the reference model.
        w0 = n_we;
        for (int i = 0; i < 3000; i++) begin
            op_valid = ($urandom_range(0, 1) == 1);
            op       = 2'($urandom_range(0, 3));
            a        = $urandom;
            b        = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            stall_in = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 29) == 0);
            div_lat  = $urandom_range(1, 6);
            tick();
        end
        op_valid = 1'b0; stall_in = 1'b0; flush = 1'b0;
        repeat (20) tick();
        chk("random_writes_seen", (n_we - w0) > 50, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
